// File: rtl/dm_pkg.sv
// Shared types for the sized data memory: access size codes, FSM states and
// the bytes-per-size helper.
package dm_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    // Number of bytes touched by an access of the given size; 0 for the illegal code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            SIZE_W:  size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Big-endian lane steering: lane k is byte M[a+k], held in bits [31-8k -: 8].
// Builds extended load data and store byte enables/data.
module dm_lane_mux
    import dm_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] rd_bytes_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [3:0]        wr_be_o,
    output logic [DATA_W-1:0] wr_bytes_o
);

    always_comb begin
        load_data_o = '0;
        wr_be_o     = '0;
        wr_bytes_o  = '0;
        case (size_i)
            SIZE_B: begin
                load_data_o = unsigned_i ? {24'h0, rd_bytes_i[31:24]}
                                         : {{24{rd_bytes_i[31]}}, rd_bytes_i[31:24]};
                wr_be_o     = 4'b0001;
                wr_bytes_o  = {wdata_i[7:0], 24'h0};
            end
            SIZE_H: begin
                load_data_o = unsigned_i ? {16'h0, rd_bytes_i[31:16]}
                                         : {{16{rd_bytes_i[31]}}, rd_bytes_i[31:16]};
                wr_be_o     = 4'b0011;
                wr_bytes_o  = {wdata_i[15:0], 16'h0};
            end
            SIZE_W: begin
                load_data_o = rd_bytes_i;
                wr_be_o     = 4'b1111;
                wr_bytes_o  = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_sized_ctrl.sv
// Handshaked byte-addressed big-endian data memory with byte/half/word access,
// programmable wait states and error reporting. DM_ALIGN_CHECK_EN enables the misalignment check.
module dm_sized_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EXT_W = ADDR_W + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [7:0]         mem_q [DEPTH];
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic               cur_wr_c;
    logic [1:0]         cur_size_c;
    logic               cur_uns_c;
    logic [ADDR_W-1:0]  cur_addr_c;
    logic [31:0]        cur_wdata_c;
    logic               accept_c;
    logic               commit_c;
    logic               range_err_c;
    logic               align_err_c;
    logic               err_c;
    logic [EXT_W-1:0]   lane_addr_c [4];
    logic [31:0]        rd_bytes_c;
    logic [31:0]        load_data_c;
    logic [3:0]         wr_be_c;
    logic [31:0]        wr_bytes_c;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // With no wait states the commit edge is the acceptance edge, so the live request is used there.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_wr_c    = req_write;
            cur_size_c  = req_size;
            cur_uns_c   = req_unsigned;
            cur_addr_c  = req_addr;
            cur_wdata_c = req_wdata;
        end else begin
            cur_wr_c    = wr_q;
            cur_size_c  = size_q;
            cur_uns_c   = uns_q;
            cur_addr_c  = addr_q;
            cur_wdata_c = wdata_q;
        end
    end

    assign accept_c = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign commit_c = (accept_c && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));

    // Range check in one extra bit so the end address never wraps.
    assign range_err_c = (EXT_W'(cur_addr_c) + EXT_W'(size_bytes(cur_size_c))) > EXT_W'(DEPTH);

`ifdef DM_ALIGN_CHECK_EN
    assign align_err_c = ((cur_size_c == SIZE_H) && cur_addr_c[0]) ||
                         ((cur_size_c == SIZE_W) && (cur_addr_c[1:0] != 2'b00));
`else
    assign align_err_c = 1'b0;
`endif

    assign err_c = (cur_size_c == SIZE_BAD) || range_err_c || align_err_c;

    // Gather the four big-endian lanes starting at the access address.
    always_comb begin
        rd_bytes_c = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr_c[k] = EXT_W'(cur_addr_c) + EXT_W'(k);
            if (lane_addr_c[k] < EXT_W'(DEPTH)) begin
                rd_bytes_c[31-8*k -: 8] = mem_q[IDX_W'(lane_addr_c[k])];
            end
        end
    end

    dm_lane_mux u_lane_mux (
        .size_i      (cur_size_c),
        .unsigned_i  (cur_uns_c),
        .rd_bytes_i  (rd_bytes_c),
        .wdata_i     (cur_wdata_c),
        .load_data_o (load_data_c),
        .wr_be_o     (wr_be_c),
        .wr_bytes_o  (wr_bytes_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (commit_c) begin
                resp_err_q   <= err_c;
                resp_rdata_q <= (err_c || cur_wr_c) ? '0 : load_data_c;
                if (cur_wr_c && !err_c) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wr_be_c[k]) begin
                            mem_q[IDX_W'(lane_addr_c[k])] <= wr_bytes_c[31-8*k -: 8];
                        end
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        wr_q        <= req_write;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
